// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Imported by the serial subtractor top.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, borrow out bo.
// Purely combinational bit slice.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference bit and borrow generated from the three inputs
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock.
// Result and borrow-out publish only when the last bit is done.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             nb;

    full_subtractor u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (borrow),
        .d  (d_bit),
        .bo (nb)
    );

    // Handshake FSM plus operand, result and borrow shift datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    d_sr   <= {d_bit, d_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= nb;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff  <= {d_bit, d_sr[WIDTH-1:1]};
                        bout  <= nb;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of the serial subtractor
// against a plain integer subtraction model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer a - b - c, borrow iff a < b + c.
    task automatic model(input int x, input int y, input int c,
                         output logic [W-1:0] d, output logic bo);
        int r;
        r  = x - y - c;
        d  = r[W-1:0];
        bo = (x < y + c);
    endtask

    // Present a request for one clock; returns after the accepting edge.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc);
        a     = ta;
        b     = tb_;
        bin   = tc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done; n0 is how many edges already passed since acceptance.
    task automatic wait_done(input string tag, input int n0,
                             input bit hchk, input logic [W-1:0] hold);
        int n;
        int bc;
        n  = n0;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            if (hchk) chk({tag, "_hold"}, 32'(diff), 32'(hold));
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n - n0 + 1, W + 2 - n0);
        if (n0 == 1) chk({tag, "_busycycles"}, bc, W);
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ta,
                                input logic [W-1:0] tb_, input logic tc);
        logic [W-1:0] ed;
        logic         eb;
        model(int'(ta), int'(tb_), int'(tc), ed, eb);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
    endtask

    task automatic op(input string tag, input logic [W-1:0] ta,
                      input logic [W-1:0] tb_, input logic tc);
        launch(ta, tb_, tc);
        wait_done(tag, 1, 1'b0, '0);
        check_result(tag, ta, tb_, tc);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_bout", 32'(bout), 0);
        rst = 1'b0;
        @(negedge clk);

        op("t1", 4'b0101, 4'b0011, 1'b0);
        chk("t1_abs_diff", 32'(diff), 32'b0010);
        op("t2", 4'b0110, 4'b0101, 1'b1);
        op("t3a", 4'b0110, 4'b1111, 1'b0);
        chk("t3a_abs_bout", 32'(bout), 1);
        op("t3b", 4'b1111, 4'b1111, 1'b1);

        launch(4'b1000, 4'b0001, 1'b0);
        @(negedge clk);
        launch(4'b0000, 4'b0000, 1'b0);
        wait_done("t4", 3, 1'b0, '0);
        check_result("t4", 4'b1000, 4'b0001, 1'b0);
        chk("t4_abs_diff", 32'(diff), 32'b0111);
        no_done("t4_dropped", 2 * W + 2);

        launch(4'b0011, 4'b0001, 1'b0);
        wait_done("t5a", 1, 1'b0, '0);
        check_result("t5a", 4'b0011, 4'b0001, 1'b0);
        launch(4'b0000, 4'b0001, 1'b0);
        wait_done("t5b", 1, 1'b1, 4'b0010);
        check_result("t5b", 4'b0000, 4'b0001, 1'b0);
        chk("t5b_abs_diff", 32'(diff), 32'b1111);
        @(negedge clk);
        chk("t5b_done_pulse", 32'(done), 0);

        launch(4'b1100, 4'b0011, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_diff", 32'(diff), 0);
        chk("t6_bout", 32'(bout), 0);
        no_done("t6_nodone", 2 * W + 2);
        op("t6_after", 4'b1001, 4'b0100, 1'b0);
        chk("t6_abs_diff", 32'(diff), 32'b0101);

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            op("rnd", ra, rb, rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
